// File: rtl/instruction_fetch_if.sv
// Handshake and bus bundle between the fetch sequencer, byte memory and the
// downstream 16-bit instruction register load port.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  Start;
  logic                  PCLoad;
  logic [ADDR_WIDTH-1:0] PCIn;
  logic [7:0]            MemData;
  logic                  MemReady;
  logic                  MemRead;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [15:0]           IrI;
  logic [2:0]            IrFunSel;
  logic                  IrE;
  logic [ADDR_WIDTH-1:0] PC;
  logic                  Busy;
  logic                  Done;

  modport slave (
    input  Start, PCLoad, PCIn, MemData, MemReady,
    output MemRead, MemAddress, IrI, IrFunSel, IrE, PC, Busy, Done
  );

  modport master (
    output Start, PCLoad, PCIn, MemData, MemReady,
    input  MemRead, MemAddress, IrI, IrFunSel, IrE, PC, Busy, Done
  );
endinterface

// File: rtl/instruction_fetch.sv
// Two-byte instruction fetch sequencer: reads low then high byte from byte-wide
// memory and loads them into the instruction register, advancing the PC per byte.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  instruction_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    WRITE_HI
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pcInc_d;
  logic                  memRead_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [15:0]           irI_q;
  logic [2:0]            irFunSel_q;
  logic                  irE_q;
  logic                  busy_q;
  logic                  done_q;

  assign pcInc_d = pc_q + ADDR_WIDTH'(1);

  // IrE and Done are single-cycle pulses, so they default low on every edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      memRead_q  <= 1'b0;
      memAddr_q  <= '0;
      irI_q      <= '0;
      irFunSel_q <= '0;
      irE_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      irE_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.PCLoad) begin
            pc_q <= bus.PCIn;
          end
          if (bus.Start) begin
            state_q   <= FETCH_LO;
            memRead_q <= 1'b1;
            memAddr_q <= bus.PCLoad ? bus.PCIn : pc_q;
            busy_q    <= 1'b1;
          end
        end
        FETCH_LO: begin
          if (bus.MemReady) begin
            state_q    <= FETCH_HI;
            pc_q       <= pcInc_d;
            memAddr_q  <= pcInc_d;
            irI_q      <= {8'h00, bus.MemData};
            irFunSel_q <= 3'b101;
            irE_q      <= 1'b1;
          end
        end
        FETCH_HI: begin
          if (bus.MemReady) begin
            state_q    <= WRITE_HI;
            pc_q       <= pcInc_d;
            memRead_q  <= 1'b0;
            irI_q      <= {8'h00, bus.MemData};
            irFunSel_q <= 3'b110;
            irE_q      <= 1'b1;
            done_q     <= 1'b1;
          end
        end
        WRITE_HI: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          memRead_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MemRead    = memRead_q;
  assign bus.MemAddress = memAddr_q;
  assign bus.IrI        = irI_q;
  assign bus.IrFunSel   = irFunSel_q;
  assign bus.IrE        = irE_q;
  assign bus.PC         = pc_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Two-byte instruction fetch sequencer for the ALU System datapath. On a Start request it reads a 16-bit instruction from byte-wide memory, one byte per handshake, and writes it into the downstream 16-bit instruction register. The write goes through that register's I/FunSel/E load port, low byte first (FunSel 101), then high byte (FunSel 110). It owns the program counter and advances it by one per byte fetched.

## Interface
- ADDR_WIDTH, 16, width of PC and MemAddress
- RESET_PC, 16'h0000, PC value after reset
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  fetch request; sampled only in IDLE
- PCLoad  in  1  load PC from PCIn; sampled only in IDLE
- PCIn  in  ADDR_WIDTH  new PC value
- MemData  in  8  byte returned by memory; valid when MemReady=1
- MemReady  in  1  memory handshake acknowledge
- MemRead  out  1  memory read request, registered
- MemAddress  out  ADDR_WIDTH  byte address, registered; equals PC while MemRead=1
- IrI  out  16  data to instruction register I port
- IrFunSel  out  3  instruction register function select
- IrE  out  1  instruction register enable, one-cycle pulse per byte
- PC  out  ADDR_WIDTH  current program counter
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse; high-byte write issued this cycle

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, WRITE_HI. All outputs are registered.
- IDLE: if PCLoad=1, then PC <= PCIn. If Start=1, go to FETCH_LO. If both are high, the fetch uses PCIn as its first address.
- FETCH_LO: MemRead=1, MemAddress=PC. The request is held with a stable address until the edge on which MemReady=1. On that edge:
  - capture MemData
  - PC <= PC+1
  - next cycle: IrI={8'h00,MemData}, IrFunSel=3'b101, IrE=1
  - go to FETCH_HI
- FETCH_HI: MemRead=1, MemAddress=PC (the incremented value). The low-byte IrE pulse occurs in the first cycle of this state. On the MemReady=1 edge:
  - capture MemData
  - PC <= PC+1
  - go to WRITE_HI
- WRITE_HI (one cycle): MemRead=0, IrI={8'h00,MemData}, IrFunSel=3'b110, IrE=1, Done=1. Next state is IDLE.
- IrE=0 in all cycles except the two write pulses. IrFunSel and IrI hold their last values when IrE=0; their reset value is 0.
- PC arithmetic is modulo 2^ADDR_WIDTH. 16'hFFFF+1 wraps to 16'h0000, so a fetch at FFFF takes its high byte from 0000.
- Start and PCLoad are ignored while Busy=1. They are not queued.
- MemReady is ignored while MemRead=0.
- Reset (async, any state): state=IDLE, PC=RESET_PC. MemRead, IrE, Done, Busy, IrI, IrFunSel and MemAddress are all 0. A fetch in progress is abandoned, and no IrE is issued after reset asserts.

## Timing
- Start is sampled at edge 0. MemRead rises in cycle 1.
- With MemReady=1 throughout:
  - low byte captured at edge 1
  - low-byte IrE in cycle 2, during which the high-byte request is also active
  - high byte captured at edge 2
  - cycle 3: high-byte IrE, Done=1
  - cycle 4: IDLE, Busy=0
- Minimum Start-to-Done latency is 3 cycles. Each memory wait cycle adds one cycle.
- The downstream register loads on the edge ending the cycle in which IrE=1. The full instruction is therefore present at the end of the Done cycle.
- The earliest Start that is accepted is in the cycle after Done (cycle 4), sampled at the edge ending cycle 4. Back-to-back fetches therefore have a 4-cycle period.

## Test plan
- Reset, then Start with MemReady=1, memory[0]=8'h34 and memory[1]=8'h12:
  - IrE pulses in cycle 2 (IrFunSel=101, IrI=16'h0034) and cycle 3 (IrFunSel=110, IrI=16'h0012)
  - Done in cycle 3
  - downstream register holds 16'h1234, PC=2
- MemReady held low for 3 cycles in FETCH_LO, then for 2 cycles in FETCH_HI:
  - MemRead and MemAddress stay stable during each wait
  - Done arrives at cycle 8
  - only two IrE pulses occur
- PCLoad=1 with PCIn=16'hFFFF and Start in the same IDLE cycle:
  - addresses FFFF then 0000 are requested
  - PC ends at 16'h0001
- Start and PCLoad pulsed while Busy=1: no effect on the current fetch or on PC. After Done, a fresh Start fetches from the incremented PC.
- Reset asserted asynchronously in FETCH_HI after the low-byte write:
  - all outputs go to 0 immediately and PC=RESET_PC
  - no high-byte IrE and no Done
  - after release, a Start refetches from RESET_PC
